// File: rtl/ps2_key_event_queue_if.sv
// ps2_key_event_queue_if
// Groups the two streaming handshakes of the PS/2 key event queue.
//   in_valid/in_byte/in_ready : raw scan bytes from the PS/2 receiver
//   ev_valid/ev_data/ev_ready : decoded key events {brk, ext, code[7:0]}
// Modports:
//   master : the surrounding system (receiver side drives bytes, consumer pops events)
//   slave  : the key event queue itself
interface ps2_key_event_queue_if;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic       ev_ready;

    modport master (
        output in_valid, in_byte, ev_ready,
        input  in_ready, ev_valid, ev_data
    );

    modport slave (
        input  in_valid, in_byte, ev_ready,
        output in_ready, ev_valid, ev_data
    );
endinterface

// File: rtl/ps2_key_event_queue.sv
// ps2_key_event_queue
// Assembles the raw PS/2 scan byte stream (E0/F0/E1 prefixes) into complete
// key events and queues them in a DEPTH-entry FIFO, so a slow consumer loses
// no keystrokes. A legacy 32-bit cur_key register mirrors the last event.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   en          : 0 flushes decoder/FIFO/cur_key and drains input bytes
//   bus (slave) : byte input handshake and event output handshake
//   level       : FIFO occupancy
//   ovf/ovf_clr : sticky "event dropped, FIFO full" flag and its clear
//   cur_key     : last decoded event in legacy prefix-byte format
// Optional feature macro: PS2_REPEAT_FILTER_EN (typematic repeat filter).
module ps2_key_event_queue #(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] IDLE_KEY   = 32'h0000F01C,
    parameter int          PAUSE_SKIP = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    ps2_key_event_queue_if.slave   bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    input  logic                   ovf_clr,
    output logic [31:0]            cur_key
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SKW = $clog2(PAUSE_SKIP + 1);

    typedef enum logic [2:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0,
        PAUSE
    } state_t;

    state_t         state;
    logic [SKW-1:0] skip;
    logic           accept;
    logic           emit_raw;
    logic           emit;
    logic [9:0]     emit_ev;
    logic [7:0]     b;

    logic [9:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           full;
    logic           pop;
    logic           push_ok;

    assign b            = bus.in_byte;
    assign bus.in_ready = ~reset;
    assign accept       = bus.in_valid && bus.in_ready && en;

    // Mealy decode of the accepted byte: which event (if any) this byte completes.
    always_comb begin
        emit_raw = 1'b0;
        emit_ev  = {2'b00, b};
        if (accept) begin
            case (state)
                IDLE: begin
                    if (!(b inside {8'hE0, 8'hF0, 8'hE1, 8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE}))
                        emit_raw = 1'b1;
                end
                GOT_E0: begin
                    if (!(b inside {8'hF0, 8'hE0, 8'h12})) begin
                        emit_raw = 1'b1;
                        emit_ev  = {2'b01, b};
                    end
                end
                GOT_F0: begin
                    if (!(b inside {8'hF0, 8'hE0})) begin
                        emit_raw = 1'b1;
                        emit_ev  = {2'b10, b};
                    end
                end
                GOT_E0F0: begin
                    if (b != 8'h12) begin
                        emit_raw = 1'b1;
                        emit_ev  = {2'b11, b};
                    end
                end
                PAUSE: begin
                    if (skip == SKW'(1)) begin
                        emit_raw = 1'b1;
                        emit_ev  = {2'b00, 8'hE1};
                    end
                end
                default: emit_raw = 1'b0;
            endcase
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    // One bit per {ext, code}: set while a key is held so its typematic
    // repeats are swallowed. Pause is a pseudo-key and bypasses the bitmap.
    logic [511:0] held;

    assign emit = emit_raw && !(state != PAUSE && !emit_ev[9] && held[emit_ev[8:0]]);

    always_ff @(posedge clk) begin
        if (reset || !en)
            held <= '0;
        else if (emit_raw && state != PAUSE)
            held[emit_ev[8:0]] <= ~emit_ev[9];
    end
`else
    assign emit = emit_raw;
`endif

    // Prefix-sequence decoder; it only moves on an accepted byte.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            state <= IDLE;
            skip  <= '0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (b == 8'hE0)
                        state <= GOT_E0;
                    else if (b == 8'hF0)
                        state <= GOT_F0;
                    else if (b == 8'hE1) begin
                        state <= PAUSE;
                        skip  <= SKW'(PAUSE_SKIP);
                    end
                end
                GOT_E0: begin
                    if (b == 8'hF0)
                        state <= GOT_E0F0;
                    else if (b != 8'hE0)
                        state <= IDLE;
                end
                GOT_F0: begin
                    if (b == 8'hE0)
                        state <= GOT_E0F0;
                    else if (b != 8'hF0)
                        state <= IDLE;
                end
                GOT_E0F0: state <= IDLE;
                PAUSE: begin
                    skip <= skip - SKW'(1);
                    if (skip == SKW'(1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Legacy register: re-expands the event into its original prefix bytes.
    always_ff @(posedge clk) begin
        if (reset || !en)
            cur_key <= IDLE_KEY;
        else if (emit) begin
            case (emit_ev[9:8])
                2'b00:   cur_key <= {24'h0, emit_ev[7:0]};
                2'b01:   cur_key <= {16'h0, 8'hE0, emit_ev[7:0]};
                2'b10:   cur_key <= {16'h0, 8'hF0, emit_ev[7:0]};
                default: cur_key <= {8'h0, 8'hE0, 8'hF0, emit_ev[7:0]};
            endcase
        end
    end

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop     = (count != '0) && bus.ev_ready;
    assign push_ok = emit && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset; entries are only read while count covers them.
    always_ff @(posedge clk) begin
        if (!reset && en && push_ok)
            mem[wr_ptr] <= emit_ev;
    end

    // A drop in the same cycle as a clear wins; en=0 leaves the flag alone.
    always_ff @(posedge clk) begin
        if (reset)
            ovf <= 1'b0;
        else if (en) begin
            if (emit && full && !pop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    assign bus.ev_valid = (count != '0);
    assign bus.ev_data  = mem[rd_ptr];
    assign level        = count;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// tb_ps2_key_event_queue
// Drives directed scan sequences and a randomized byte stream into
// ps2_key_event_queue and checks every cycle against a queue-based model.
// Honors PS2_REPEAT_FILTER_EN the same way the design does.
module tb_ps2_key_event_queue;

    localparam int          DEPTH      = 8;
    localparam logic [31:0] IDLE_KEY   = 32'h0000F01C;
    localparam int          PAUSE_SKIP = 7;

    logic                   clk;
    logic                   reset;
    logic                   en;
    logic [$clog2(DEPTH):0] level;
    logic                   ovf;
    logic                   ovf_clr;
    logic [31:0]            cur_key;

    ps2_key_event_queue_if bus ();

    ps2_key_event_queue #(
        .DEPTH      (DEPTH),
        .IDLE_KEY   (IDLE_KEY),
        .PAUSE_SKIP (PAUSE_SKIP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .bus     (bus),
        .level   (level),
        .ovf     (ovf),
        .ovf_clr (ovf_clr),
        .cur_key (cur_key)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state: pending prefixes as flags, events as a queue.
    logic [9:0]   mq [$];
    logic [9:0]   cap [$];
    logic [9:0]   expq [$];
    bit           m_ext;
    bit           m_brk;
    int           m_pause;
    bit           m_ovf;
    logic [31:0]  m_key;
    bit [511:0]   m_held;
    bit           m_live = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] keyOf(input logic [9:0] ev);
        logic [31:0] k;
        k = {24'h0, ev[7:0]};
        if (ev[8])
            k = k | (ev[9] ? 32'h00E00000 : 32'h0000E000);
        if (ev[9])
            k = k | 32'h0000F000;
        return k;
    endfunction

    task automatic decodeByte(input logic [7:0] b, output bit emit, output logic [9:0] ev);
        emit = 1'b0;
        ev   = '0;
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) begin
                emit = 1'b1;
                ev   = {2'b00, 8'hE1};
            end
            return;
        end
        if (!m_ext && !m_brk) begin
            if (b == 8'hE0)
                m_ext = 1'b1;
            else if (b == 8'hF0)
                m_brk = 1'b1;
            else if (b == 8'hE1)
                m_pause = PAUSE_SKIP;
            else if (!(b inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE})) begin
                emit = 1'b1;
                ev   = {2'b00, b};
            end
        end else if (m_ext && m_brk) begin
            if (b != 8'h12) begin
                emit = 1'b1;
                ev   = {2'b11, b};
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (m_ext) begin
            if (b == 8'hF0)
                m_brk = 1'b1;
            else if (b != 8'hE0) begin
                if (b != 8'h12) begin
                    emit = 1'b1;
                    ev   = {2'b01, b};
                end
                m_ext = 1'b0;
            end
        end else begin
            if (b == 8'hE0)
                m_ext = 1'b1;
            else if (b != 8'hF0) begin
                emit  = 1'b1;
                ev    = {2'b10, b};
                m_brk = 1'b0;
            end
        end
`ifdef PS2_REPEAT_FILTER_EN
        if (emit) begin
            if (ev[9])
                m_held[ev[8:0]] = 1'b0;
            else if (m_held[ev[8:0]])
                emit = 1'b0;
            else
                m_held[ev[8:0]] = 1'b1;
        end
`endif
    endtask

    task automatic modelClear();
        mq.delete();
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        m_pause = 0;
        m_key   = IDLE_KEY;
        m_held  = '0;
    endtask

    // Model advances on each rising edge from the inputs held across it.
    always @(posedge clk) begin : model
        bit         do_pop;
        bit         do_emit;
        bit         dropped;
        logic [9:0] ev;
        if (reset) begin
            modelClear();
            m_ovf  = 1'b0;
            m_live = 1'b1;
        end else if (!en) begin
            modelClear();
        end else begin
            do_pop  = (mq.size() != 0) && bus.ev_ready;
            do_emit = 1'b0;
            dropped = 1'b0;
            ev      = '0;
            if (bus.in_valid)
                decodeByte(bus.in_byte, do_emit, ev);
            if (do_pop)
                void'(mq.pop_front());
            if (do_emit) begin
                m_key = keyOf(ev);
                if (mq.size() < DEPTH)
                    mq.push_back(ev);
                else
                    dropped = 1'b1;
            end
            if (dropped)
                m_ovf = 1'b1;
            else if (ovf_clr)
                m_ovf = 1'b0;
        end
    end

    // Compare process on the falling edge, plus a log of what the consumer pops.
    always @(negedge clk) begin
        if (m_live) begin
            checkOutput("in_ready", {31'h0, bus.in_ready}, {31'h0, !reset});
            checkOutput("ev_valid", {31'h0, bus.ev_valid}, {31'h0, mq.size() != 0});
            if (mq.size() != 0)
                checkOutput("ev_data", {22'h0, bus.ev_data}, {22'h0, mq[0]});
            checkOutput("level", 32'(level), 32'(mq.size()));
            checkOutput("ovf", {31'h0, ovf}, {31'h0, m_ovf});
            checkOutput("cur_key", cur_key, m_key);
            if (!reset && en && bus.ev_valid && bus.ev_ready)
                cap.push_back(bus.ev_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cap.delete();
        expq.delete();
    endtask

    task automatic checkCap(input string name);
        checkOutput({name, " count"}, 32'(cap.size()), 32'(expq.size()));
        for (int i = 0; i < cap.size() && i < expq.size(); i++)
            checkOutput(name, {22'h0, cap[i]}, {22'h0, expq[i]});
    endtask

    initial begin
        reset        = 1'b1;
        en           = 1'b1;
        ovf_clr      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        bus.ev_ready = 1'b1;
        idle(2);
        reset = 1'b0;
        checkOutput("reset cur_key", cur_key, 32'h0000F01C);
        checkOutput("reset level", 32'(level), 32'd0);
        checkOutput("reset ev_valid", {31'h0, bus.ev_valid}, 32'd0);

        // make then break of the same key
        doReset();
        applyStimulus(8'h1C); applyStimulus(8'hF0); applyStimulus(8'h1C);
        idle(3);
        expq = '{10'h01C, 10'h21C};
        checkCap("make_break");
        checkOutput("make_break cur_key", cur_key, 32'h0000F01C);
        checkOutput("make_break level", 32'(level), 32'd0);

        // extended make/break, then fake shift
        doReset();
        applyStimulus(8'hE0); applyStimulus(8'h75);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
        applyStimulus(8'hE0); applyStimulus(8'h12);
        idle(3);
        expq = '{10'h175, 10'h375};
        checkCap("extended");
        checkOutput("extended cur_key", cur_key, 32'h00E0F075);

        // overflow, clear, then simultaneous pop+push when full
        doReset();
        bus.ev_ready = 1'b0;
        for (int i = 0; i < 10; i++)
            applyStimulus(8'h15 + 8'(i));
        idle(1);
        checkOutput("ovf level", 32'(level), 32'd8);
        checkOutput("ovf set", {31'h0, ovf}, 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checkOutput("ovf clear", {31'h0, ovf}, 32'd0);
        bus.ev_ready = 1'b1;
        applyStimulus(8'h2B);
        bus.ev_ready = 1'b0;
        checkOutput("full pop+push level", 32'(level), 32'd8);
        bus.ev_ready = 1'b1;
        idle(12);
        expq = '{10'h015, 10'h016, 10'h017, 10'h018, 10'h019, 10'h01A, 10'h01B, 10'h01C, 10'h02B};
        checkCap("overflow order");

        // Pause sequence collapses to one event, decoding resumes afterwards
        doReset();
        applyStimulus(8'hE1); applyStimulus(8'h14); applyStimulus(8'h77);
        applyStimulus(8'hE1); applyStimulus(8'hF0); applyStimulus(8'h14);
        applyStimulus(8'hF0); applyStimulus(8'h77);
        idle(3);
        checkOutput("pause count", 32'(cap.size()), 32'd1);
        applyStimulus(8'h1C);
        idle(3);
        expq = '{10'h0E1, 10'h01C};
        checkCap("pause");

        // en=0 mid-sequence flushes FIFO and prefix state
        doReset();
        bus.ev_ready = 1'b0;
        applyStimulus(8'h1C);
        applyStimulus(8'hE0);
        en = 1'b0;
        step();
        checkOutput("disable level", 32'(level), 32'd0);
        checkOutput("disable cur_key", cur_key, 32'h0000F01C);
        en = 1'b1;
        bus.ev_ready = 1'b1;
        applyStimulus(8'h75);
        idle(3);
        expq = '{10'h075};
        checkCap("disable");

        // typematic repeats
        doReset();
        applyStimulus(8'h1C); applyStimulus(8'h1C); applyStimulus(8'h1C);
        applyStimulus(8'hF0); applyStimulus(8'h1C);
        idle(3);
`ifdef PS2_REPEAT_FILTER_EN
        expq = '{10'h01C, 10'h21C};
`else
        expq = '{10'h01C, 10'h01C, 10'h01C, 10'h21C};
`endif
        checkCap("repeat");

        // randomized stream, checked every cycle by the compare process
        doReset();
        for (int c = 0; c < 4000; c++) begin
            int k;
            reset        = ($urandom_range(0, 199) == 0);
            en           = ($urandom_range(0, 99) != 0);
            bus.ev_ready = ($urandom_range(0, 99) < 40);
            ovf_clr      = ($urandom_range(0, 99) < 5);
            bus.in_valid = ($urandom_range(0, 99) < 60);
            k = $urandom_range(0, 9);
            case (k)
                0:       bus.in_byte = 8'hE0;
                1:       bus.in_byte = 8'hF0;
                2:       bus.in_byte = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h12;
                3:       bus.in_byte = 8'h12;
                4:       bus.in_byte = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'h00;
                5, 6:    bus.in_byte = ($urandom_range(0, 1) == 0) ? 8'h1C : 8'h75;
                default: bus.in_byte = 8'($urandom_range(0, 255));
            endcase
            step();
        end
        reset        = 1'b0;
        en           = 1'b1;
        bus.in_valid = 1'b0;
        ovf_clr      = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
